// File: rtl/dsam_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : dsam_decoder
//  Brief    : Receive-side inverse of dsam_encoder. Each encoded word is XORed
//             with the previous encoded word seen on the same interleaved
//             channel. Channels are chosen round-robin by a word counter that
//             runs in lock-step with the encoder. The output is one registered
//             stage with a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module dsam_decoder #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 4     // must equal 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  resync,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid,
   input  logic                  out_ready
);

   // Per-channel history of the last encoded word, plus the channel pointer.
   // The pointer wraps naturally because CHANNELS is a power of two.
   logic [DATA_WIDTH-1:0] hist_q [CHANNELS];
   logic [DATA_WIDTH-1:0] hist_d [CHANNELS];
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  out_valid_q, out_valid_d;

   logic                  accept_w;

   // The output register is the only buffer, so accept is possible whenever
   // it is empty or being drained this cycle.
   assign in_ready  = !out_valid_q || out_ready;
   assign accept_w  = in_valid && in_ready;
   assign out       = out_q;
   assign out_valid = out_valid_q;

   // Next-state: resync clears the history first, so a word accepted in the
   // same cycle decodes against an all-zero channel 0.
   always_comb begin
      logic [ADDR_WIDTH-1:0] idx;
      logic [DATA_WIDTH-1:0] prev;

      hist_d      = hist_q;
      ptr_d       = ptr_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      idx         = ptr_q;
      prev        = hist_q[ptr_q];

      if (resync) begin
         for (int i = 0; i < CHANNELS; i++) begin
            hist_d[i] = '0;
         end
         ptr_d = '0;
         idx   = '0;
         prev  = '0;
      end

      if (accept_w) begin
         out_d       = in ^ prev;
         hist_d[idx] = in;
         ptr_d       = idx + 1'b1;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            hist_q[i] <= '0;
         end
         ptr_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            hist_q[i] <= hist_d[i];
         end
         ptr_q       <= ptr_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
`default_nettype wire
